debouncer: RTL and testbench

Input conditioning stage that synchronizes an asynchronous single-bit level (push-button, external strobe, slow status pin) into the `clk` domain and filters out glitches and contact bounce. It sits directly upstream of the edge detector: its registered `out` is a clean, stable level whose transitions are safe to convert into one-cycle rise/fall pulses. The level changes only after the synchronized input has held a new value for a programmable number of consecutive cycles.

---
 rtl/debouncer.sv | 75 +++++++
 tb/tb_debouncer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/debouncer.sv
// Level debouncer: optional synchronizer followed by a stable-count qualifier.
// Define DEBOUNCER_SYNC_EN to compile in the SYNC_STAGES-deep synchronizer.
module debouncer #(
  parameter int   SYNC_STAGES   = 2,
  parameter int   STABLE_CYCLES = 16,
  parameter logic POR_VALUE     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out,
  output logic busy
);

  localparam int             CW   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]  LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0]  ZERO = {CW{1'b0}};

  logic          s_s;
  logic          out_r;
  logic          busy_r;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_next_s;
  logic          out_next_s;

`ifdef DEBOUNCER_SYNC_EN
  logic [SYNC_STAGES-1:0] sync_r;

  // Synchronizer chain bringing the raw level into the clk domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{POR_VALUE}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], in};
    end
  end

  assign s_s = sync_r[SYNC_STAGES-1];
`else
  localparam int unused_sync_stages = SYNC_STAGES;

  assign s_s = in;
`endif

  // Compare/count qualifier: a mismatch streak must reach STABLE_CYCLES to flip out
  always_comb begin
    cnt_next_s = cnt_r;
    out_next_s = out_r;
    if (s_s == out_r) begin
      cnt_next_s = ZERO;
    end else if (cnt_r == LAST) begin
      out_next_s = s_s;
      cnt_next_s = ZERO;
    end else begin
      cnt_next_s = cnt_r + 1'b1;
    end
  end

  // State and output registers; busy reflects the counter value after the edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_r  <= POR_VALUE;
      cnt_r  <= ZERO;
      busy_r <= 1'b0;
    end else begin
      out_r  <= out_next_s;
      cnt_r  <= cnt_next_s;
      busy_r <= (cnt_next_s != ZERO);
    end
  end

  assign out  = out_r;
  assign busy = busy_r;

endmodule

// File: tb/tb_debouncer.sv
// Directed self-checking bench for debouncer (SYNC_STAGES=2, STABLE_CYCLES=4, POR_VALUE=0).
// Expected edge counts are offset by the synchronizer depth D, which is 0 when it is compiled out.
module tb_debouncer;

`ifdef DEBOUNCER_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif

  logic clk;
  logic rst;
  logic din;
  logic dout;
  logic busy;

  int n_checks;
  int n_fail;

  debouncer #(
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(4),
    .POR_VALUE    (1'b0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .in  (din),
    .out (dout),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one edge with din = v set up beforehand, then settle before sampling.
  task automatic step(input logic v);
    din = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    din = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_bit("reset_out", dout, 1'b0);
    check_bit("reset_busy", busy, 1'b0);
    rst = 1'b0;

    // Idle low for 10 cycles
    for (int i = 1; i <= 10; i++) begin
      step(1'b0);
      check_bit("idle_out", dout, 1'b0);
      check_bit("idle_busy", busy, 1'b0);
    end

    // Clean 0->1: busy from edge D+1, out at edge D+4 with busy low
    for (int i = 1; i <= D + 7; i++) begin
      step(1'b1);
      check_bit("rise_out", dout, (i >= D + 4) ? 1'b1 : 1'b0);
      check_bit("rise_busy", busy, (i >= D + 1 && i < D + 4) ? 1'b1 : 1'b0);
    end

    // Clean 1->0 (same qualification for the other polarity)
    for (int i = 1; i <= D + 6; i++) begin
      step(1'b0);
      check_bit("fall_out", dout, (i >= D + 4) ? 1'b0 : 1'b1);
    end

    // Bounce 1,0,1,0 at 3 cycles each, then held 1 from edge 13
    for (int j = 1; j <= 12 + D + 6; j++) begin
      step((j > 12) ? 1'b1 : ((((j - 1) / 3) % 2 == 0) ? 1'b1 : 1'b0));
      check_bit("bounce_out", dout, (j >= 16 + D) ? 1'b1 : 1'b0);
    end

    // Return to 0
    for (int i = 1; i <= D + 6; i++) begin
      step(1'b0);
      check_bit("ret_out", dout, (i >= D + 4) ? 1'b0 : 1'b1);
    end

    // 3-cycle pulse is swallowed
    for (int i = 1; i <= 10; i++) begin
      step((i <= 3) ? 1'b1 : 1'b0);
      check_bit("pulse3_out", dout, 1'b0);
    end

    // 4-cycle pulse propagates, then the return qualifies back to 0
    for (int i = 1; i <= D + 10; i++) begin
      step((i <= 4) ? 1'b1 : 1'b0);
      check_bit("pulse4_out", dout, (i >= D + 4 && i < D + 8) ? 1'b1 : 1'b0);
    end

    // Reset mid-count: cnt reaches 2 at edge D+2
    for (int i = 1; i <= D + 2; i++) begin
      step(1'b1);
    end
    check_bit("pre_rst_busy", busy, 1'b1);
    check_bit("pre_rst_out", dout, 1'b0);
    rst = 1'b1;
    #1;
    check_bit("async_rst_busy", busy, 1'b0);
    check_bit("async_rst_out", dout, 1'b0);
    @(posedge clk);
    #1;
    check_bit("held_rst_busy", busy, 1'b0);
    check_bit("held_rst_out", dout, 1'b0);
    rst = 1'b0;

    // Full requalification after release
    for (int i = 1; i <= D + 6; i++) begin
      step(1'b1);
      check_bit("post_rst_out", dout, (i >= D + 4) ? 1'b1 : 1'b0);
      check_bit("post_rst_busy", busy, (i >= D + 1 && i < D + 4) ? 1'b1 : 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
